hmac_msg_streamer: RTL and testbench

Initiator-side message source for hmac_top. A host loads up to DEPTH 32-bit message words into an internal buffer, then pulses go. The block pulses start_hmac, streams the words over the msg_word/msg_valid/msg_last/msg_ready handshake, waits for the done rising edge, and latches the MAC. It sits between the control/host logic and hmac_top, and replaces bench-driven message traffic in the integrated design.

---
 rtl/hmac_pkg.sv | 18 +
 rtl/hmac_msg_buf.sv | 28 ++
 rtl/hmac_msg_streamer.sv | 157 +++++++++++++++
 tb/tb_hmac_msg_streamer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmac_pkg.sv
// Shared definitions for the HMAC message streamer: state encoding,
// datapath widths and default parameter values.
package hmac_pkg;

    localparam int MSG_W       = 32;
    localparam int MAC_W       = 512;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_TIMEOUT = 500000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_STREAM    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FINISH    = 3'd4
    } state_e;

endpackage

// File: rtl/hmac_msg_buf.sv
// Message word buffer: one synchronous write port, one combinational
// read port addressed by the streaming index. Contents are not reset.
module hmac_msg_buf
    import hmac_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [MSG_W-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [MSG_W-1:0] rdata_o
);

    logic [MSG_W-1:0] mem_q [DEPTH];

    // Host write port; the caller gates we_i so the buffer is frozen during a run
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hmac_msg_streamer.sv
// Initiator-side message source for hmac_top: buffers up to DEPTH words,
// pulses start, streams words with valid/ready, waits for the done edge
// and latches the MAC (or reports a timeout / illegal length on err).
module hmac_msg_streamer
    import hmac_pkg::*;
#(
    parameter int          DEPTH   = DEF_DEPTH,
    parameter int          AW      = $clog2(DEPTH),
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [MSG_W-1:0] wr_data_i,
    input  logic [AW:0]      msg_len_i,
    input  logic             go_i,
    output logic             busy_o,
    output logic             start_hmac_o,
    output logic [MSG_W-1:0] msg_word_o,
    output logic             msg_valid_o,
    output logic             msg_last_o,
    input  logic             msg_ready_i,
    input  logic             hmac_done_i,
    input  logic [MAC_W-1:0] hmac_value_i,
    output logic [MAC_W-1:0] mac_out_o,
    output logic             mac_valid_o,
    output logic             err_o
);

    localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_L    = (AW+1)'(1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [AW:0]      idx_q, idx_d;      // one bit wider so len=DEPTH never wraps
    logic [AW:0]      len_q, len_d;
    logic [31:0]      tmo_q, tmo_d;
    logic             done_q;
    logic [MAC_W-1:0] mac_q, mac_d;
    logic             err_q, err_d;
    logic [MSG_W-1:0] rd_data;

    logic len_ok, xfer, is_last, done_rise, tmo_hit;

    assign len_ok    = (msg_len_i != '0) && (msg_len_i <= DEPTH_L);
    assign xfer      = (state_q == ST_STREAM) && msg_ready_i;
    assign is_last   = (idx_q == (len_q - ONE_L));
    assign done_rise = hmac_done_i && !done_q;
    assign tmo_hit   = (tmo_q == TMO_LAST);

    hmac_msg_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk_i   (clk_i),
        .we_i    (wr_en_i && (state_q == ST_IDLE)),
        .waddr_i (wr_addr_i),
        .wdata_i (wr_data_i),
        .raddr_i (idx_q[AW-1:0]),
        .rdata_o (rd_data)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a done edge wins over a coincident timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (go_i && len_ok) state_d = ST_START;
            ST_START:     state_d = ST_STREAM;
            ST_STREAM:    if (xfer && is_last) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (done_rise)    state_d = ST_FINISH;
                else if (tmo_hit) state_d = ST_IDLE;
            end
            ST_FINISH:    state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        busy_o       = (state_q != ST_IDLE);
        start_hmac_o = (state_q == ST_START);
        msg_valid_o  = 1'b0;
        msg_last_o   = 1'b0;
        msg_word_o   = '0;
        mac_valid_o  = (state_q == ST_FINISH);
        if (state_q == ST_STREAM) begin
            msg_valid_o = 1'b1;
            msg_last_o  = is_last;
            msg_word_o  = rd_data;
        end
    end

    // Counter, length, MAC and error next-state values
    always_comb begin
        idx_d = idx_q;
        len_d = len_q;
        tmo_d = tmo_q;
        mac_d = mac_q;
        err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (go_i && len_ok) begin
                    len_d = msg_len_i;
                    idx_d = '0;
                end else if (go_i) begin
                    err_d = 1'b1;
                end
            end
            ST_START: tmo_d = '0;
            ST_STREAM: if (xfer) idx_d = idx_q + ONE_L;
            ST_WAIT_DONE: begin
                if (done_rise) begin
                    mac_d = hmac_value_i;
                end else if (tmo_hit) begin
                    err_d = 1'b1;
                end
                if (tmo_q != '1) tmo_d = tmo_q + 32'd1;
            end
            default: ;
        endcase
    end

    // Datapath registers; done history samples every cycle so a level
    // already high on WAIT_DONE entry is never mistaken for an edge
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q  <= '0;
            len_q  <= '0;
            tmo_q  <= '0;
            done_q <= 1'b0;
            mac_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            len_q  <= len_d;
            tmo_q  <= tmo_d;
            done_q <= hmac_done_i;
            mac_q  <= mac_d;
            err_q  <= err_d;
        end
    end

    assign mac_out_o = mac_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_hmac_msg_streamer.sv
// Scoreboard bench for hmac_msg_streamer: stimulus pushes expected words
// and MACs into queues, a negedge monitor pops and compares.
module tb_hmac_msg_streamer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TMO   = 100;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          wr_en_i = 1'b0;
    logic [AW-1:0] wr_addr_i = '0;
    logic [31:0]   wr_data_i = '0;
    logic [AW:0]   msg_len_i = '0;
    logic          go_i = 1'b0;
    logic          busy_o, start_hmac_o, msg_valid_o, msg_last_o;
    logic [31:0]   msg_word_o;
    logic          msg_ready_i = 1'b1;
    logic          hmac_done_i = 1'b0;
    logic [511:0]  hmac_value_i = '0;
    logic [511:0]  mac_out_o;
    logic          mac_valid_o, err_o;

    hmac_msg_streamer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .msg_len_i(msg_len_i), .go_i(go_i), .busy_o(busy_o),
        .start_hmac_o(start_hmac_o), .msg_word_o(msg_word_o), .msg_valid_o(msg_valid_o),
        .msg_last_o(msg_last_o), .msg_ready_i(msg_ready_i), .hmac_done_i(hmac_done_i),
        .hmac_value_i(hmac_value_i), .mac_out_o(mac_out_o), .mac_valid_o(mac_valid_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0, passed = 0;
    int go_cyc = -10, wd_entry = 0;
    int xfer_cnt = 0, start_cnt = 0, mac_cnt = 0, err_cnt = 0, stall_cnt = 0;
    bit tmo_expect = 0, bp = 0;
    int pi = 0;
    logic [32:0]  exp_q[$];
    logic [511:0] exp_mac[$];
    int           xfer_cyc[$];
    logic [2:0][0:0] dummy;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s: event not as required (t=%0t)", name, $time);
    endtask

    // Ready driver: always high, or the 1,0,0,1,0,1 backpressure pattern
    logic [5:0] pat = 6'b101001;
    initial forever begin
        @(posedge clk_i); #2;
        if (bp) begin msg_ready_i = pat[pi % 6]; pi++; end
        else msg_ready_i = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        bit          stall_pend = 0, prev_valid = 0;
        logic [31:0] st_word;
        logic        st_last;
        logic [32:0] e;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                stall_pend = 0; prev_valid = 0;
            end else begin
                if (stall_pend) begin
                    chk("valid_held", msg_valid_o, 1'b1);
                    if (msg_valid_o) begin
                        chk("word_stable", msg_word_o, st_word);
                        chk("last_stable", msg_last_o, st_last);
                    end
                end
                if (msg_valid_o && !prev_valid) chk("valid_rise_cycle", cyc, go_cyc + 2);
                if (msg_valid_o && msg_ready_i) begin
                    if (exp_q.size() == 0) fail("unexpected_word");
                    else begin
                        e = exp_q.pop_front();
                        chk("word", msg_word_o, e[31:0]);
                        chk("last", msg_last_o, e[32]);
                    end
                    xfer_cyc.push_back(cyc);
                    xfer_cnt++;
                    if (msg_last_o) wd_entry = cyc + 1;
                    stall_pend = 0;
                end else if (msg_valid_o) begin
                    stall_pend = 1; st_word = msg_word_o; st_last = msg_last_o; stall_cnt++;
                end else stall_pend = 0;
                prev_valid = msg_valid_o;
                if (start_hmac_o) begin start_cnt++; chk("start_cycle", cyc, go_cyc + 1); end
                if (mac_valid_o) begin
                    mac_cnt++;
                    if (exp_mac.size() == 0) fail("unexpected_mac_valid");
                    else chk("mac_out", mac_out_o, exp_mac.pop_front());
                end
                if (err_o) begin
                    err_cnt++;
                    if (tmo_expect) chk("timeout_err_cycle", cyc, wd_entry + TMO);
                    else chk("err_cycle", cyc, go_cyc + 1);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        wr_en_i = 1; wr_addr_i = AW'(a); wr_data_i = d;
        tick();
        wr_en_i = 0;
    endtask

    task automatic go_run(input int len);
        msg_len_i = (AW+1)'(len); go_i = 1; go_cyc = cyc;
        tick();
        go_i = 0;
    endtask

    task automatic expect_words(input int first, input int len, input logic [31:0] w0);
        for (int i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1), (i == 0) ? w0 : 32'(first + i)});
    endtask

    task automatic wait_xfers(input int target);
        int n = 0;
        while (xfer_cnt < target && n < 300) begin @(posedge clk_i); n++; end
        #1;
        if (xfer_cnt < target) fail("xfer_wait_timeout");
    endtask

    task automatic finish_mac(input logic [511:0] v);
        int n = 0, target = mac_cnt + 1;
        exp_mac.push_back(v);
        hmac_value_i = v;
        tick(2);
        hmac_done_i = 1;
        tick();
        hmac_done_i = 0;
        while (mac_cnt < target && n < 20) begin @(posedge clk_i); n++; end
        #1;
        if (mac_cnt < target) fail("mac_wait_timeout");
        tick();
        chk("busy_after_finish", busy_o, 1'b0);
    endtask

    initial begin
        int base, s0, e0, t;
        tick(3);
        reset_i = 0;
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", msg_valid_o, 0);
        chk("rst_word", msg_word_o, 0);
        chk("rst_mac", mac_out_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_start", start_hmac_o, 0);

        // Length-3 run, ready high: three consecutive transfers
        load(0, 32'hDEADBEEF); load(1, 32'hCAFEBABE); load(2, 32'h00000011);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        exp_q.push_back({1'b0, 32'hCAFEBABE});
        exp_q.push_back({1'b1, 32'h00000011});
        base = xfer_cyc.size(); s0 = start_cnt;
        go_run(3);
        wait_xfers(xfer_cnt + 3);
        chk("len3_consecutive", xfer_cyc[base + 2] - xfer_cyc[base], 2);
        finish_mac({8{64'h123456789abcdef0}});
        chk("len3_one_start", start_cnt - s0, 1);

        // Backpressure run with the same words
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        exp_q.push_back({1'b0, 32'hCAFEBABE});
        exp_q.push_back({1'b1, 32'h00000011});
        base = xfer_cnt; t = stall_cnt;
        pi = 0; bp = 1;
        go_run(3);
        wait_xfers(base + 3);
        bp = 0;
        chk("bp_xfer_count", xfer_cnt - base, 3);
        chk("bp_stalls_seen", stall_cnt > t, 1'b1);
        finish_mac({16{32'hA5A5_0F0F}});
        chk("bp_queue_empty", exp_q.size(), 0);

        // Illegal lengths: err once per go, no start, never busy
        s0 = start_cnt; e0 = err_cnt;
        go_run(0);
        chk("len0_busy", busy_o, 0);
        tick(2);
        go_run(DEPTH + 1);
        chk("len17_busy", busy_o, 0);
        tick(2);
        chk("illegal_err_count", err_cnt - e0, 2);
        chk("illegal_no_start", start_cnt, s0);

        // Full buffer; go and wr_en mid-run must be ignored
        for (int i = 0; i < DEPTH; i++) load(i, 32'(i));
        expect_words(0, DEPTH, 32'h0);
        base = xfer_cyc.size(); s0 = start_cnt;
        go_run(DEPTH);
        tick(4);
        go_i = 1; wr_en_i = 1; wr_addr_i = '0; wr_data_i = 32'hFFFFFFFF; msg_len_i = 5'd2;
        tick();
        go_i = 0; wr_en_i = 0;
        wait_xfers(xfer_cnt + (DEPTH - (xfer_cnt - base)));
        chk("full_xfers", xfer_cyc.size() - base, DEPTH);
        chk("full_consecutive", xfer_cyc[base + DEPTH - 1] - xfer_cyc[base], DEPTH - 1);
        finish_mac({64{8'h3C}});
        chk("full_one_start", start_cnt - s0, 1);

        // Timeout run: words 0,1 prove the mid-run write was dropped
        expect_words(0, 2, 32'h0);
        e0 = err_cnt; t = mac_cnt;
        tmo_expect = 1;
        go_run(2);
        begin
            int n = 0;
            while (err_cnt == e0 && n < TMO + 50) begin @(posedge clk_i); n++; end
            #1;
        end
        tmo_expect = 0;
        chk("timeout_err_count", err_cnt - e0, 1);
        tick(3);
        chk("timeout_no_mac", mac_cnt, t);
        chk("timeout_mac_kept", mac_out_o, {64{8'h3C}});
        chk("timeout_idle", busy_o, 0);

        // Done level high on entry is not an edge
        hmac_done_i = 1;
        exp_q.push_back({1'b1, 32'h0});
        t = mac_cnt;
        go_run(1);
        wait_xfers(xfer_cnt + 1);
        tick(5);
        chk("level_not_edge", mac_cnt, t);
        chk("level_still_busy", busy_o, 1);
        hmac_done_i = 0;
        finish_mac({4{128'hFEDC_BA98_7654_3210_0011_2233_4455_6677}});

        // Reset mid-stream
        expect_words(0, DEPTH, 32'h0);
        e0 = err_cnt; t = mac_cnt;
        go_run(DEPTH);
        wait_xfers(xfer_cnt + 3);
        reset_i = 1;
        tick();
        chk("rst_mid_valid", msg_valid_o, 0);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_mac", mac_out_o, 0);
        reset_i = 0;
        exp_q.delete();
        tick(3);
        chk("rst_mid_no_err", err_cnt, e0);
        chk("rst_mid_no_mac", mac_cnt, t);

        // Clean run after reset; buffer survived reset
        expect_words(0, 3, 32'h0);
        go_run(3);
        wait_xfers(xfer_cnt + 3);
        finish_mac({2{256'h0BAD_F00D_0000_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC}});
        chk("final_word_queue", exp_q.size(), 0);
        chk("final_mac_queue", exp_mac.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
